greater_than: RTL and testbench

GREATER_THAN -- requirements
Module: greater_than

---
 rtl/greater_than.sv | 81 ++++++++
 tb/tb_greater_than.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/greater_than.sv
// Registered magnitude comparator: one-cycle latency A>B / A==B / A<B flags
// plus a saturating count of valid compares that found A > B.
module greater_than #(
  parameter int WIDTH      = 2,
  parameter bit SIGNED_CMP = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             F,
  output logic             EQ,
  output logic             LT,
  output logic             out_valid,
  output logic [CNT_W-1:0] gt_count
);

  // Handshake: in_valid qualifies A/B for exactly the cycle it is high; out_valid
  // is that strobe one cycle later. There is no ready, so results never stall.

  logic gt_w;
  logic eq_w;

  generate
    if (SIGNED_CMP) begin : g_signed
      assign gt_w = $signed(A) > $signed(B);
    end else begin : g_unsigned
      assign gt_w = A > B;
    end
  endgenerate

  assign eq_w = (A == B);

  logic             f_q,   f_d;
  logic             eq_q,  eq_d;
  logic             lt_q,  lt_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    f_d   = f_q;
    eq_d  = eq_q;
    lt_d  = lt_q;
    vld_d = in_valid;
    cnt_d = cnt_q;
    if (in_valid) begin
      f_d  = gt_w;
      eq_d = eq_w;
      lt_d = !gt_w && !eq_w;
      // Saturate rather than wrap so a long run of hits never reads as few.
      if (gt_w && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_q   <= 1'b0;
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      f_q   <= f_d;
      eq_q  <= eq_d;
      lt_q  <= lt_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign F         = f_q;
  assign EQ        = eq_q;
  assign LT        = lt_q;
  assign out_valid = vld_q;
  assign gt_count  = cnt_q;

endmodule

// File: tb/tb_greater_than.sv
// Directed bench for greater_than: unsigned, signed and narrow-counter instances
// share one stimulus stream; each check targets the instance it concerns.
module tb_greater_than;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] a;
  logic [1:0] b;

  logic       f_u, eq_u, lt_u, ov_u;
  logic [7:0] cnt_u;
  logic       f_s, eq_s, lt_s, ov_s;
  logic [7:0] cnt_s;
  logic       f_c, eq_c, lt_c, ov_c;
  logic [1:0] cnt_c;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] exp_q[$];

  typedef struct {
    logic [3:0] ab;
    logic [2:0] fel; // {F, EQ, LT}
  } vec_t;

  vec_t sweep[16];

  always #5 clk = ~clk;

  greater_than #(.WIDTH(2), .SIGNED_CMP(1'b0), .CNT_W(8)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
    .F(f_u), .EQ(eq_u), .LT(lt_u), .out_valid(ov_u), .gt_count(cnt_u)
  );

  greater_than #(.WIDTH(2), .SIGNED_CMP(1'b1), .CNT_W(8)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
    .F(f_s), .EQ(eq_s), .LT(lt_s), .out_valid(ov_s), .gt_count(cnt_s)
  );

  greater_than #(.WIDTH(2), .SIGNED_CMP(1'b0), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(a), .B(b),
    .F(f_c), .EQ(eq_c), .LT(lt_c), .out_valid(ov_c), .gt_count(cnt_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] av, input logic [1:0] bv);
    rst      = r;
    in_valid = v;
    a        = av;
    b        = bv;
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sweep[0]  = '{4'd0,  3'b010}; sweep[1]  = '{4'd1,  3'b001};
    sweep[2]  = '{4'd2,  3'b001}; sweep[3]  = '{4'd3,  3'b001};
    sweep[4]  = '{4'd4,  3'b100}; sweep[5]  = '{4'd5,  3'b010};
    sweep[6]  = '{4'd6,  3'b001}; sweep[7]  = '{4'd7,  3'b001};
    sweep[8]  = '{4'd8,  3'b100}; sweep[9]  = '{4'd9,  3'b100};
    sweep[10] = '{4'd10, 3'b010}; sweep[11] = '{4'd11, 3'b001};
    sweep[12] = '{4'd12, 3'b100}; sweep[13] = '{4'd13, 3'b100};
    sweep[14] = '{4'd14, 3'b100}; sweep[15] = '{4'd15, 3'b010};

    drive(1'b1, 1'b0, 2'd0, 2'd0);
    tick();
    tick();
    check("reset_state_u", {f_u, eq_u, lt_u, ov_u}, 4'b0000);
    check("reset_cnt_u", cnt_u, 0);
    check("reset_cnt_c", cnt_c, 0);

    // Exhaustive unsigned sweep, back-to-back with no idle cycles.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, sweep[i].ab[3:2], sweep[i].ab[1:0]);
      tick();
      check($sformatf("sweep_valid_%0d", i), ov_u, 1'b1);
      check($sformatf("sweep_fel_%0d", i), {f_u, eq_u, lt_u}, sweep[i].fel);
      check($sformatf("sweep_onehot_%0d", i), 32'(f_u) + 32'(eq_u) + 32'(lt_u), 1);
    end
    check("sweep_gt_count", cnt_u, 6);

    // Latency: result one cycle after the request, held once in_valid drops.
    drive(1'b0, 1'b1, 2'd3, 2'd1);
    tick();
    check("lat_valid", ov_u, 1'b1);
    check("lat_f", f_u, 1'b1);
    drive(1'b0, 1'b0, 2'd0, 2'd0);
    tick();
    check("lat_valid_drop", ov_u, 1'b0);
    check("lat_f_hold", f_u, 1'b1);
    check("lat_cnt", cnt_u, 7);

    // Signed: -1 vs +1, then +1 vs -2.
    drive(1'b0, 1'b1, 2'b11, 2'b01);
    tick();
    check("signed_m1_p1_fel", {f_s, eq_s, lt_s}, 3'b001);
    check("unsigned_3_1_f", f_u, 1'b1);
    drive(1'b0, 1'b1, 2'b01, 2'b10);
    tick();
    check("signed_p1_m2_fel", {f_s, eq_s, lt_s}, 3'b100);
    check("unsigned_1_2_fel", {f_u, eq_u, lt_u}, 3'b001);

    // Idle hold: operands change but nothing is captured.
    drive(1'b0, 1'b0, 2'd3, 2'd0);
    tick();
    check("idle_lt_hold", lt_u, 1'b1);
    check("idle_f_hold", f_u, 1'b0);
    check("idle_valid", ov_u, 1'b0);
    check("idle_cnt_hold", cnt_u, 8);

    // Reset wins over a same-cycle request.
    drive(1'b1, 1'b1, 2'd2, 2'd0);
    tick();
    check("rst_pri_f", f_u, 1'b0);
    check("rst_pri_valid", ov_u, 1'b0);
    check("rst_pri_cnt", cnt_u, 0);
    drive(1'b0, 1'b1, 2'd0, 2'd1);
    tick();
    check("post_rst_fel", {f_u, eq_u, lt_u, ov_u}, 4'b0011);
    check("post_rst_cnt", cnt_u, 0);

    // Saturation on the 2-bit counter across seven hits.
    exp_q = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 2'd3, 2'd0);
      tick();
      check($sformatf("sat_cnt_%0d", i), cnt_c, exp_q.pop_front());
    end
    check("nosat_cnt_u", cnt_u, 7);
    drive(1'b0, 1'b0, 2'd0, 2'd0);
    tick();
    check("sat_hold", cnt_c, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
